// File: rtl/cache_refill_ctrl.sv
// Refill controller for a 4-way set-associative cache. It looks up one CPU request at a time,
// refills a missed line from main memory in four beats, and keeps a 3-bit tree PLRU per set.
module cache_refill_ctrl #(
  parameter int tagSize    = 20,
  parameter int indexWidth = 8,
  parameter int NoOfSets   = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  // valid/ready: a transfer happens on a rising edge where both are 1; the initiator
  // holds valid and its payload stable until that edge, and ready may depend on state only.
  input  logic                           reqValid,
  output logic                           reqReady,
  input  logic                           reqWrite,
  input  logic [2:0]                     reqMode,
  input  logic [tagSize-1:0]             reqTag,
  input  logic [indexWidth-1:0]          reqIndex,
  input  logic [1:0]                     reqOffset,
  input  logic [31:0]                    reqWData,
  input  logic [3:0]                     wayHit,
  output logic                           memReqValid,
  input  logic                           memReqReady,
  output logic [tagSize+indexWidth+1:0]  memReqAddr,
  input  logic                           memRespValid,
  input  logic [31:0]                    memRespData,
  output logic [tagSize-1:0]             tag,
  output logic [indexWidth-1:0]          index,
  output logic [1:0]                     offset,
  output logic [2:0]                     mode,
  output logic [31:0]                    wData,
  output logic                           wEnDWay0,
  output logic                           wEnDWay1,
  output logic                           wEnDWay2,
  output logic                           wEnDWay3,
  output logic                           wEnMainMemW0,
  output logic                           wEnMainMemW1,
  output logic                           wEnMainMemW2,
  output logic                           wEnMainMemW3,
  output logic [1:0]                     waySelect,
  output logic                           hit,
  output logic                           done,
  output logic [2:0]                     stateDbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    FILL_REQ  = 3'd2,
    FILL_WAIT = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [tagSize-1:0]      tag_q;
  logic [indexWidth-1:0]   index_q;
  logic [1:0]              offset_q;
  logic [2:0]              mode_q;
  logic [31:0]             wdata_q;
  logic                    write_q;
  logic [1:0]              victim_q, victim_d;
  logic [1:0]              beat_q, beat_d;
  logic [1:0]              way_sel_q, way_sel_d;
  logic [2:0]              plru_q [NoOfSets];

  logic                    capture;
  logic                    plru_we;
  logic [1:0]              plru_way;
  logic [2:0]              plru_cur;
  logic [2:0]              plru_next;
  logic [1:0]              plru_victim;
  logic [1:0]              hit_way;
  logic [3:0]              wen_d_vec;
  logic [3:0]              wen_m_vec;

  // Bits are stored as {b2, b1, b0}; b0 picks the half, b1/b2 pick within it.
  assign plru_cur    = plru_q[index_q];
  assign plru_victim = plru_cur[0] ? (plru_cur[2] ? 2'd3 : 2'd2)
                                   : (plru_cur[1] ? 2'd1 : 2'd0);

  always_comb begin
    plru_next = plru_cur;
    case (plru_way)
      2'd0:    plru_next = {plru_cur[2], 1'b1, 1'b1};
      2'd1:    plru_next = {plru_cur[2], 1'b0, 1'b1};
      2'd2:    plru_next = {1'b1, plru_cur[1], 1'b0};
      default: plru_next = {1'b0, plru_cur[1], 1'b0};
    endcase
  end

  assign hit_way = wayHit[0] ? 2'd0 : wayHit[1] ? 2'd1 : wayHit[2] ? 2'd2 : 2'd3;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    victim_d    = victim_q;
    way_sel_d   = way_sel_q;
    reqReady    = 1'b0;
    memReqValid = 1'b0;
    hit         = 1'b0;
    done        = 1'b0;
    wen_d_vec   = 4'b0000;
    wen_m_vec   = 4'b0000;
    offset      = offset_q;
    wData       = wdata_q;
    plru_we     = 1'b0;
    plru_way    = 2'd0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          capture = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (|wayHit) begin
          hit                = 1'b1;
          done               = 1'b1;
          way_sel_d          = hit_way;
          wen_d_vec[hit_way] = write_q;
          plru_we            = 1'b1;
          plru_way           = hit_way;
          state_d            = IDLE;
        end else begin
          victim_d = plru_victim;
          beat_d   = 2'd0;
          state_d  = FILL_REQ;
        end
      end
      FILL_REQ: begin
        memReqValid = 1'b1;
        if (memReqReady) state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        offset = beat_q;
        wData  = memRespData;
        if (memRespValid) begin
          wen_m_vec[victim_q] = 1'b1;
          if (beat_q == 2'd3) begin
            state_d = FINISH;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = FILL_REQ;
          end
        end
      end
      FINISH: begin
        hit                 = 1'b1;
        done                = 1'b1;
        way_sel_d           = victim_q;
        wen_d_vec[victim_q] = write_q;
        plru_we             = 1'b1;
        plru_way            = victim_q;
        beat_d              = 2'd0;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tag_q     <= '0;
      index_q   <= '0;
      offset_q  <= '0;
      mode_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      victim_q  <= '0;
      beat_q    <= '0;
      way_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      victim_q  <= victim_d;
      beat_q    <= beat_d;
      way_sel_q <= way_sel_d;
      if (capture) begin
        tag_q    <= reqTag;
        index_q  <= reqIndex;
        offset_q <= reqOffset;
        mode_q   <= reqMode;
        wdata_q  <= reqWData;
        write_q  <= reqWrite;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NoOfSets; i++) plru_q[i] <= '0;
    end else if (plru_we) begin
      plru_q[index_q] <= plru_next;
    end
  end

  // waySelect shows the new way in the completion cycle and holds it afterwards.
  assign waySelect    = way_sel_d;
  assign memReqAddr   = {tag_q, index_q, beat_q};
  assign tag          = tag_q;
  assign index        = index_q;
  assign mode         = mode_q;
  assign stateDbg     = state_q;
  assign wEnDWay0     = wen_d_vec[0];
  assign wEnDWay1     = wen_d_vec[1];
  assign wEnDWay2     = wen_d_vec[2];
  assign wEnDWay3     = wen_d_vec[3];
  assign wEnMainMemW0 = wen_m_vec[0];
  assign wEnMainMemW1 = wen_m_vec[1];
  assign wEnMainMemW2 = wen_m_vec[2];
  assign wEnMainMemW3 = wen_m_vec[3];

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: driver tasks post a per-cycle expectation built from a
// transaction-level model (registered fields, per-set PLRU, last way); one process compares it.
module tb_cache_refill_ctrl;

  localparam int TW = 20;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqValid, reqReady, reqWrite;
  logic [2:0]    reqMode;
  logic [TW-1:0] reqTag;
  logic [IW-1:0] reqIndex;
  logic [1:0]    reqOffset;
  logic [31:0]   reqWData;
  logic [3:0]    wayHit;
  logic          memReqValid, memReqReady;
  logic [TW+IW+1:0] memReqAddr;
  logic          memRespValid;
  logic [31:0]   memRespData;
  logic [TW-1:0] tag;
  logic [IW-1:0] index;
  logic [1:0]    offset;
  logic [2:0]    mode;
  logic [31:0]   wData;
  logic          wEnDWay0, wEnDWay1, wEnDWay2, wEnDWay3;
  logic          wEnMainMemW0, wEnMainMemW1, wEnMainMemW2, wEnMainMemW3;
  logic [1:0]    waySelect;
  logic          hit, done;
  logic [2:0]    stateDbg;

  cache_refill_ctrl #(.tagSize(TW), .indexWidth(IW), .NoOfSets(256)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqMode(reqMode),
    .reqTag(reqTag), .reqIndex(reqIndex), .reqOffset(reqOffset), .reqWData(reqWData),
    .wayHit(wayHit),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .tag(tag), .index(index), .offset(offset), .mode(mode), .wData(wData),
    .wEnDWay0(wEnDWay0), .wEnDWay1(wEnDWay1), .wEnDWay2(wEnDWay2), .wEnDWay3(wEnDWay3),
    .wEnMainMemW0(wEnMainMemW0), .wEnMainMemW1(wEnMainMemW1),
    .wEnMainMemW2(wEnMainMemW2), .wEnMainMemW3(wEnMainMemW3),
    .waySelect(waySelect), .hit(hit), .done(done), .stateDbg(stateDbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct {
    logic          req_ready;
    logic          mem_req_valid;
    logic          chk_addr;
    logic [TW+IW+1:0] addr;
    logic          hit;
    logic          done;
    logic [1:0]    way_select;
    logic [3:0]    wen_d;
    logic [3:0]    wen_m;
    logic          chk_off;
    logic [1:0]    offset;
    logic          chk_wdata;
    logic [31:0]   wdata;
    logic [TW-1:0] tag;
    logic [IW-1:0] index;
    logic [2:0]    mode;
    int            pin_way;
  } exp_t;

  exp_t          cur_exp;
  bit            chk_en = 1'b0;
  int            n_checks = 0;
  int            n_err = 0;

  logic [2:0]    m_plru [256];   // {b2,b1,b0}
  logic [1:0]    m_ws;
  logic [TW-1:0] m_tag;
  logic [IW-1:0] m_idx;
  logic [2:0]    m_mode;

  function automatic logic [1:0] m_victim(input logic [2:0] p);
    if (p[0]) return p[2] ? 2'd3 : 2'd2;
    return p[1] ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [2:0] m_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] r;
    r = p;
    if (w < 2) begin r[0] = 1'b1; r[1] = (w == 0); end
    else       begin r[0] = 1'b0; r[2] = (w == 2); end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_plru[i] = 3'b000;
    m_ws = 2'd0; m_tag = '0; m_idx = '0; m_mode = '0;
  endtask

  function automatic exp_t base_exp();
    exp_t e;
    e.req_ready = 1'b0; e.mem_req_valid = 1'b0; e.chk_addr = 1'b0; e.addr = '0;
    e.hit = 1'b0; e.done = 1'b0; e.way_select = m_ws; e.wen_d = 4'b0; e.wen_m = 4'b0;
    e.chk_off = 1'b0; e.offset = 2'd0; e.chk_wdata = 1'b0; e.wdata = 32'h0;
    e.tag = m_tag; e.index = m_idx; e.mode = m_mode; e.pin_way = -1;
    return e;
  endfunction

  // Idle/reset expectation: only reqReady high, registered fields and address all zero.
  function automatic exp_t reset_exp();
    exp_t e;
    e = base_exp();
    e.req_ready = 1'b1; e.chk_addr = 1'b1; e.addr = '0;
    e.chk_off = 1'b1; e.offset = 2'd0; e.chk_wdata = 1'b1; e.wdata = 32'h0;
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("reqReady", 64'(reqReady), 64'(cur_exp.req_ready));
      chk("memReqValid", 64'(memReqValid), 64'(cur_exp.mem_req_valid));
      if (cur_exp.chk_addr) chk("memReqAddr", 64'(memReqAddr), 64'(cur_exp.addr));
      chk("hit", 64'(hit), 64'(cur_exp.hit));
      chk("done", 64'(done), 64'(cur_exp.done));
      chk("waySelect", 64'(waySelect), 64'(cur_exp.way_select));
      chk("wEnDWay", 64'({wEnDWay3, wEnDWay2, wEnDWay1, wEnDWay0}), 64'(cur_exp.wen_d));
      chk("wEnMainMemW", 64'({wEnMainMemW3, wEnMainMemW2, wEnMainMemW1, wEnMainMemW0}),
          64'(cur_exp.wen_m));
      if (cur_exp.chk_off) chk("offset", 64'(offset), 64'(cur_exp.offset));
      if (cur_exp.chk_wdata) chk("wData", 64'(wData), 64'(cur_exp.wdata));
      chk("tag", 64'(tag), 64'(cur_exp.tag));
      chk("index", 64'(index), 64'(cur_exp.index));
      chk("mode", 64'(mode), 64'(cur_exp.mode));
      if (cur_exp.pin_way >= 0) chk("waySelect_literal", 64'(waySelect), 64'(cur_exp.pin_way));
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // junk=1 drives a request that must be ignored because reqReady is low.
  task automatic drive_idle(input bit junk);
    reqValid = junk; reqWrite = junk; reqMode = junk ? 3'd7 : 3'd0;
    reqTag = junk ? '1 : '0; reqIndex = junk ? '1 : '0; reqOffset = junk ? 2'd3 : 2'd0;
    reqWData = junk ? 32'h5555AAAA : 32'h0;
    wayHit = 4'b0000; memReqReady = 1'b0; memRespValid = 1'b0; memRespData = 32'h0;
  endtask

  task automatic finish_exp(input bit wr, input logic [1:0] way, input logic [1:0] off,
                            input logic [31:0] wd, input logic [IW-1:0] ix, input int pin);
    exp_t e;
    m_ws = way;
    e = base_exp();
    e.hit = 1'b1; e.done = 1'b1; e.way_select = way;
    e.wen_d = wr ? (4'b0001 << way) : 4'b0000;
    e.chk_off = 1'b1; e.offset = off; e.chk_wdata = wr; e.wdata = wd; e.pin_way = pin;
    cur_exp = e;
    m_plru[ix] = m_touch(m_plru[ix], way);
  endtask

  task automatic do_access(input bit wr, input logic [TW-1:0] t, input logic [IW-1:0] ix,
                           input logic [1:0] off, input logic [2:0] md, input logic [31:0] wd,
                           input logic [3:0] wh, input int stall, input int wait_c,
                           input logic [31:0] base, input int pin);
    exp_t e;
    logic [1:0] way, victim;
    cyc();
    drive_idle(1'b0);
    reqValid = 1'b1; reqWrite = wr; reqTag = t; reqIndex = ix; reqOffset = off;
    reqMode = md; reqWData = wd;
    e = base_exp(); e.req_ready = 1'b1; cur_exp = e;
    m_tag = t; m_idx = ix; m_mode = md;
    cyc();
    drive_idle(1'b1);
    wayHit = wh;
    if (wh != 4'b0000) begin
      way = 2'd3;
      for (int i = 3; i >= 0; i--) if (wh[i]) way = 2'(i);
      finish_exp(wr, way, off, wd, ix, pin);
    end else begin
      victim = m_victim(m_plru[ix]);
      cur_exp = base_exp();
      for (int b = 0; b < 4; b++) begin
        e = base_exp(); e.mem_req_valid = 1'b1; e.chk_addr = 1'b1; e.addr = {t, ix, 2'(b)};
        for (int s = 0; s < ((b == 0) ? stall : 0); s++) begin
          cyc();
          drive_idle(1'b1);
          memRespValid = (s == 0); memRespData = 32'hBADBAD00;
          cur_exp = e;
        end
        cyc();
        drive_idle(1'b1);
        memReqReady = 1'b1;
        cur_exp = e;
        for (int w = 0; w < wait_c; w++) begin
          cyc();
          drive_idle(1'b1);
          cur_exp = base_exp();
        end
        cyc();
        drive_idle(1'b0);
        memRespValid = 1'b1; memRespData = base + 32'(b);
        e = base_exp(); e.wen_m = 4'b0001 << victim;
        e.chk_off = 1'b1; e.offset = 2'(b); e.chk_wdata = 1'b1; e.wdata = base + 32'(b);
        cur_exp = e;
      end
      cyc();
      drive_idle(1'b0);
      finish_exp(wr, victim, off, wd, ix, pin);
    end
  endtask

  // Miss with 5 cycles of backpressure on beat 0, then reset while waiting for beat 1.
  task automatic reset_mid_refill(input logic [TW-1:0] t, input logic [IW-1:0] ix);
    exp_t e;
    logic [1:0] victim;
    cyc();
    drive_idle(1'b0);
    reqValid = 1'b1; reqTag = t; reqIndex = ix; reqOffset = 2'd1; reqMode = 3'd5;
    e = base_exp(); e.req_ready = 1'b1; cur_exp = e;
    m_tag = t; m_idx = ix; m_mode = 3'd5;
    victim = m_victim(m_plru[ix]);
    cyc();
    drive_idle(1'b0);
    cur_exp = base_exp();
    e = base_exp(); e.mem_req_valid = 1'b1; e.chk_addr = 1'b1; e.addr = {t, ix, 2'd0};
    for (int s = 0; s < 5; s++) begin
      cyc();
      drive_idle(1'b0);
      cur_exp = e;
    end
    cyc(); drive_idle(1'b0); memReqReady = 1'b1; cur_exp = e;
    cyc(); drive_idle(1'b0); memRespValid = 1'b1; memRespData = 32'h11110000;
    e = base_exp(); e.wen_m = 4'b0001 << victim; e.chk_off = 1'b1; e.offset = 2'd0;
    e.chk_wdata = 1'b1; e.wdata = 32'h11110000; cur_exp = e;
    e = base_exp(); e.mem_req_valid = 1'b1; e.chk_addr = 1'b1; e.addr = {t, ix, 2'd1};
    cyc(); drive_idle(1'b0); memReqReady = 1'b1; cur_exp = e;
    cyc(); drive_idle(1'b0); cur_exp = base_exp();
    cyc();
    drive_idle(1'b0);
    reset = 1'b0; memRespValid = 1'b1; memRespData = 32'h22220000;
    model_reset();
    cur_exp = reset_exp();
    for (int k = 0; k < 3; k++) begin
      cyc();
      drive_idle(1'b0);
      reset = 1'b1; memRespValid = 1'b1; memRespData = 32'h33330000;
      cur_exp = reset_exp();
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b0;
    drive_idle(1'b0);
    model_reset();
    for (int k = 0; k < 2; k++) begin
      cyc();
      cur_exp = reset_exp();
      chk_en = 1'b1;
    end
    cyc(); reset = 1'b1; cur_exp = reset_exp();
    cyc(); drive_idle(1'b0); memRespValid = 1'b1; memRespData = 32'h0BADF00D;
    cur_exp = reset_exp();

    // read hit in way 2
    do_access(1'b0, 20'h0ABCD, 8'd5, 2'd1, 3'd2, 32'h0, 4'b0100, 0, 0, 32'h0, 2);
    // read miss refill, data A0..A3, response one cycle after the request
    do_access(1'b0, 20'h12345, 8'd3, 2'd0, 3'd1, 32'h0, 4'b0000, 0, 1, 32'hA0, 0);
    // four misses to one fresh set: victims 0, 2, 1, 3
    do_access(1'b0, 20'h00001, 8'd9, 2'd0, 3'd0, 32'h0, 4'b0000, 0, 0, 32'h100, 0);
    do_access(1'b0, 20'h00002, 8'd9, 2'd1, 3'd0, 32'h0, 4'b0000, 0, 0, 32'h200, 2);
    do_access(1'b0, 20'h00003, 8'd9, 2'd2, 3'd0, 32'h0, 4'b0000, 0, 0, 32'h300, 1);
    do_access(1'b0, 20'h00004, 8'd9, 2'd3, 3'd0, 32'h0, 4'b0000, 0, 0, 32'h400, 3);
    // write hit in way 1 at offset 2
    do_access(1'b1, 20'h00777, 8'd7, 2'd2, 3'd3, 32'hDEADBEEF, 4'b0010, 0, 0, 32'h0, 1);
    // several ways match: lowest wins
    do_access(1'b0, 20'h00777, 8'd7, 2'd3, 3'd4, 32'h0, 4'b1110, 0, 0, 32'h0, 1);
    // write miss with backpressure and slow responses; set 9 PLRU is back to 000
    do_access(1'b1, 20'h00005, 8'd9, 2'd1, 3'd6, 32'hCAFEF00D, 4'b0000, 2, 2, 32'h500, 0);
    // set 3 would pick way 2 now; reset clears that
    reset_mid_refill(20'h0F0F0, 8'd3);
    do_access(1'b0, 20'h0F0F0, 8'd3, 2'd2, 3'd1, 32'h0, 4'b0000, 0, 0, 32'hC0, 0);
    do_access(1'b1, 20'h0ABCD, 8'd5, 2'd3, 3'd2, 32'h01234567, 4'b1000, 0, 0, 32'h0, 3);

    cyc();
    drive_idle(1'b0);
    cur_exp = base_exp(); cur_exp.req_ready = 1'b1;
    cyc();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
